// File: rtl/data_mem_unit_if.sv
// Load/store port between the core (master) and the data RAM (slave).
// The flat request and response buses are kept so the core can pack and unpack them itself.
interface data_mem_unit_if #(
    parameter int data_mem_addr_width_p = 12
);
    logic [35:0]                      port_flat_i;
    logic [data_mem_addr_width_p-1:0] addr;
    logic [33:0]                      port_flat_o;

    modport master (
        output port_flat_i,
        output addr,
        input  port_flat_o
    );

    modport slave (
        input  port_flat_i,
        input  addr,
        output port_flat_o
    );
endinterface

// File: rtl/data_mem_unit.sv
// Single-port, byte-addressable, little-endian data RAM on a valid/yumi handshake.
// A request is accepted in IDLE and answered with one response beat from BUSY.
module data_mem_unit #(
    parameter int data_mem_addr_width_p = 12
) (
    input  logic           clk,
    input  logic           reset,
    data_mem_unit_if.slave bus
);
    localparam int addr_w_lp = data_mem_addr_width_p;
    localparam int words_lp  = 2 ** (addr_w_lp - 2);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e state_q, state_d;
    logic [31:0] read_data_q, read_data_d;

    logic [31:0] in_write_data;
    logic        in_valid;
    logic        in_wen;
    logic        in_byte_not_word;
    logic        in_yumi;

    assign {in_write_data, in_valid, in_wen, in_byte_not_word, in_yumi} = bus.port_flat_i;

    logic [addr_w_lp-3:0] word_idx;
    logic [4:0]           lane_shift;

    assign word_idx   = bus.addr[addr_w_lp-1:2];
    assign lane_shift = {bus.addr[1:0], 3'b000};

    logic [31:0] mem [words_lp];
    logic [31:0] mem_word;
    logic [7:0]  mem_byte;

    assign mem_word = mem[word_idx];
    assign mem_byte = mem_word[lane_shift +: 8];

    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        out_valid;
    logic        out_yumi;

    always_comb begin
        state_d     = state_q;
        read_data_d = read_data_q;
        mem_we      = 1'b0;
        mem_wdata   = mem_word;
        out_valid   = 1'b0;
        out_yumi    = 1'b0;

        unique case (state_q)
            IDLE: begin
                out_yumi = in_valid;
                if (in_valid) begin
                    state_d = BUSY;
                    if (in_wen) begin
                        // Stores echo their write data so magic-address stores are observable.
                        mem_we      = 1'b1;
                        read_data_d = in_write_data;
                        if (in_byte_not_word) begin
                            mem_wdata[lane_shift +: 8] = in_write_data[7:0];
                        end else begin
                            mem_wdata = in_write_data;
                        end
                    end else if (in_byte_not_word) begin
                        read_data_d = {24'b0, mem_byte};
                    end else begin
                        read_data_d = mem_word;
                    end
                end
            end
            BUSY: begin
                out_valid = 1'b1;
                if (in_yumi) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            read_data_q <= 32'b0;
        end else begin
            state_q     <= state_d;
            read_data_q <= read_data_d;
        end
    end

    // The array is deliberately left out of reset; only the handshake state is cleared.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[word_idx] <= mem_wdata;
        end
    end

    assign bus.port_flat_o = {read_data_q, out_valid, out_yumi};
endmodule

// File: tb/tb_data_mem_unit.sv
// Directed and randomized checks of data_mem_unit against a byte-array reference model.
module tb_data_mem_unit;
    localparam int aw_lp = 12;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    data_mem_unit_if #(.data_mem_addr_width_p(aw_lp)) bus ();

    data_mem_unit #(.data_mem_addr_width_p(aw_lp)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] out_rdata;
    logic        out_valid;
    logic        out_yumi;

    assign {out_rdata, out_valid, out_yumi} = bus.port_flat_o;

    // Reference model: a flat byte array, little-endian, addresses wrap by truncation.
    logic [7:0] model_mem [2**aw_lp];

    function automatic logic [aw_lp-1:0] wordBase(input logic [aw_lp-1:0] a);
        return {a[aw_lp-1:2], 2'b00};
    endfunction

    function automatic logic [31:0] modelLoad(input logic [aw_lp-1:0] a, input logic bnw);
        logic [aw_lp-1:0] b;
        logic [31:0]      v;
        if (bnw) return {24'b0, model_mem[a]};
        b = wordBase(a);
        v = 32'b0;
        for (int k = 0; k < 4; k++) v = v | (32'(model_mem[b + aw_lp'(k)]) << (8 * k));
        return v;
    endfunction

    task automatic modelStore(input logic [aw_lp-1:0] a, input logic [31:0] d, input logic bnw);
        logic [aw_lp-1:0] b;
        if (bnw) begin
            model_mem[a] = d[7:0];
        end else begin
            b = wordBase(a);
            for (int k = 0; k < 4; k++) model_mem[b + aw_lp'(k)] = 8'((d >> (8 * k)) & 32'hFF);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic wen, input logic bnw, input logic yumi,
                                 input logic [aw_lp-1:0] a, input logic [31:0] wd);
        bus.port_flat_i = {wd, v, wen, bnw, yumi};
        bus.addr        = a;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One complete transaction with yumi held high: accept, one response beat, back to IDLE.
    task automatic doOp(input string tag, input logic wen, input logic bnw,
                        input logic [aw_lp-1:0] a, input logic [31:0] wd);
        logic [31:0] expected;
        expected = wen ? wd : modelLoad(a, bnw);
        if (wen) modelStore(a, wd, bnw);
        @(negedge clk);
        applyStimulus(1'b1, wen, bnw, 1'b1, a, wd);
        #1;
        checkOutput({tag, "_accept_yumi"}, 32'(out_yumi), 32'd1);
        checkOutput({tag, "_accept_valid"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, "_resp_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_resp_yumi"}, 32'(out_yumi), 32'd0);
        checkOutput({tag, "_resp_data"}, out_rdata, expected);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, a, wd);
        @(posedge clk);
        #1;
        checkOutput({tag, "_back_idle"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] held;
        logic [31:0] magic;
        logic [31:0] rd;
        logic        rw;
        logic        rb;
        logic [aw_lp-1:0] ra;

        checks = 0;
        errors = 0;
        reset  = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 32'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset then idle for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            checkOutput("reset_valid", 32'(out_valid), 32'd0);
            checkOutput("reset_yumi", 32'(out_yumi), 32'd0);
            checkOutput("reset_data", out_rdata, 32'd0);
            @(negedge clk);
        end

        // yumi alone in IDLE does nothing.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 12'h010, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("idle_yumi_valid", 32'(out_valid), 32'd0);

        doOp("st_word", 1'b1, 1'b0, 12'h010, 32'hDEADBEEF);
        doOp("ld_word", 1'b0, 1'b0, 12'h010, 32'h0);

        doOp("st_base", 1'b1, 1'b0, 12'h010, 32'h11223344);
        doOp("st_byte", 1'b1, 1'b1, 12'h013, 32'h555555AB);
        doOp("ld_merge", 1'b0, 1'b0, 12'h010, 32'h0);
        checkOutput("ld_merge_const", out_rdata, 32'hAB223344);
        doOp("ld_byte", 1'b0, 1'b1, 12'h013, 32'h0);
        checkOutput("ld_byte_const", out_rdata, 32'h000000AB);

        // Preload every word then read everything back.
        for (int i = 0; i < 1024; i++) doOp("preload", 1'b1, 1'b0, aw_lp'(i * 4), 32'(i * 3));
        for (int i = 0; i < 1024; i++) begin
            doOp("reload", 1'b0, 1'b0, aw_lp'(i * 4), 32'h0);
            checkOutput("reload_const", out_rdata, 32'(i * 3));
        end

        // Stall in BUSY while a second request is offered; it must be ignored.
        held = modelLoad(12'h020, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'h020, 32'h0);
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 12'h020, 32'hBADBAD00);
        for (int i = 0; i < 4; i++) begin
            checkOutput("hold_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_data", out_rdata, held);
            checkOutput("hold_yumi", 32'(out_yumi), 32'd0);
            @(posedge clk);
            #1;
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 12'h020, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("hold_release", 32'(out_valid), 32'd0);
        doOp("hold_nowrite", 1'b0, 1'b0, 12'h020, 32'h0);
        checkOutput("hold_nowrite_const", out_rdata, 32'd24);

        // Magic address store, truncated to 12 bits.
        magic = 32'h600DBEEF;
        doOp("magic_st", 1'b1, 1'b0, magic[aw_lp-1:0], 32'hCAFEF00D);
        doOp("magic_ld", 1'b0, 1'b0, 12'hEEC, 32'h0);
        checkOutput("magic_ld_const", out_rdata, 32'hCAFEF00D);

        // Reset while BUSY drops the response but keeps the committed write.
        modelStore(12'h100, 32'h0BADF00D, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 12'h100, 32'h0BADF00D);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'h100, 32'h0);
        checkOutput("rst_busy_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("rst_busy_drop", 32'(out_valid), 32'd0);
        checkOutput("rst_busy_data", out_rdata, 32'd0);
        doOp("rst_commit", 1'b0, 1'b0, 12'h100, 32'h0);

        // Randomized mixed traffic against the model.
        for (int i = 0; i < 300; i++) begin
            rw = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            ra = aw_lp'($urandom);
            rd = $urandom;
            doOp("rand", rw, rb, ra, rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
